gate_actuator: RTL



---
 rtl/gate_actuator_if.sv | 25 ++
 rtl/gate_actuator.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/gate_actuator_if.sv
// Level-crossing barrier drive bundle.
// Permission and limit switches in, motor/lamp/buzzer/status out.
interface gate_actuator_if;
  logic       gate_open;
  logic       lim_up;
  logic       lim_down;
  logic       motor_up;
  logic       motor_down;
  logic       warn_lamp;
  logic       buzzer;
  logic       gate_fault;
  logic [2:0] state;

  modport master (
    output gate_open, lim_up, lim_down,
    input  motor_up, motor_down, warn_lamp,
    input  buzzer, gate_fault, state
  );

  modport slave (
    input  gate_open, lim_up, lim_down,
    output motor_up, motor_down, warn_lamp,
    output buzzer, gate_fault, state
  );
endinterface

// File: rtl/gate_actuator.sv
// Barrier sequencer: warning, lowering, raising, travel timeouts.
// Outputs are registered decodes of the next state and flash phase.
module gate_actuator #(
  parameter int unsigned TICK_DIV   = 500000,
  parameter int unsigned WARN_TICKS = 600,
  parameter int unsigned MOVE_TICKS = 1600,
  parameter int unsigned FLASH_DIV  = 50000000
) (
  input logic            mClk,
  input logic            Reset,
  gate_actuator_if.slave bus
);

  localparam int unsigned TMAX =
    (WARN_TICKS > MOVE_TICKS) ? WARN_TICKS : MOVE_TICKS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] WARN_LAST = TW'(WARN_TICKS - 1);
  localparam logic [TW-1:0] MOVE_LAST = TW'(MOVE_TICKS - 1);
  localparam logic [FW-1:0] FL_LAST   = FW'(FLASH_DIV - 1);

  typedef enum logic [2:0] {
    S_OPEN   = 3'd0,
    S_WARN   = 3'd1,
    S_LOWER  = 3'd2,
    S_CLOSED = 3'd3,
    S_RAISE  = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic          g_q;
  logic          u_s_q, u_q;
  logic          d_s_q, d_q;
  logic [PW-1:0] pre_q, pre_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [FW-1:0] fl_q, fl_d;
  logic          ph_q, ph_d;
  logic          tick;
  logic          mup_q, mup_d;
  logic          mdn_q, mdn_d;
  logic          lamp_q, lamp_d;
  logic          buzz_q, buzz_d;
  logic          flt_q, flt_d;

  assign tick = (pre_q == PRE_LAST);

  // Next state: switch conflict, then switches, then permission, then timeout.
  always_comb begin
    state_d = state_q;
    if (u_q && d_q && state_q != S_FAULT) begin
      state_d = S_FAULT;
    end else begin
      case (state_q)
        S_OPEN:   if (!g_q) state_d = S_WARN;
        S_WARN: begin
          if (g_q) state_d = S_RAISE;
          else if (tick && tmr_q == WARN_LAST) state_d = S_LOWER;
        end
        S_LOWER: begin
          if (d_q) state_d = S_CLOSED;
          else if (tick && tmr_q == MOVE_LAST) state_d = S_FAULT;
        end
        S_CLOSED: if (g_q) state_d = S_RAISE;
        S_RAISE: begin
          if (u_q) state_d = S_OPEN;
          else if (!g_q) state_d = S_LOWER;
          else if (tick && tmr_q == MOVE_LAST) state_d = S_FAULT;
        end
        S_FAULT:  state_d = S_FAULT;
        default:  state_d = S_FAULT;
      endcase
    end
  end

  // Tick prescaler and tick timer, both restarted on any state change.
  always_comb begin
    pre_d = pre_q + 1'b1;
    tmr_d = tmr_q;
    if (state_d != state_q) begin
      pre_d = '0;
      tmr_d = '0;
    end else if (tick) begin
      pre_d = '0;
      tmr_d = tmr_q + 1'b1;
    end
  end

  // Free-running flash; restarts lit when a warning begins from OPEN.
  always_comb begin
    fl_d = fl_q + 1'b1;
    ph_d = ph_q;
    if (state_q == S_OPEN && state_d == S_WARN) begin
      fl_d = '0;
      ph_d = 1'b1;
    end else if (fl_q == FL_LAST) begin
      fl_d = '0;
      ph_d = ~ph_q;
    end
  end

  // Moore output decode of the upcoming state and phase.
  always_comb begin
    mup_d  = 1'b0;
    mdn_d  = 1'b0;
    lamp_d = 1'b0;
    buzz_d = 1'b0;
    flt_d  = 1'b0;
    unique case (state_d)
      S_OPEN: ;
      S_WARN: begin
        lamp_d = ph_d;
        buzz_d = 1'b1;
      end
      S_LOWER: begin
        mdn_d  = 1'b1;
        lamp_d = ph_d;
        buzz_d = 1'b1;
      end
      S_CLOSED: lamp_d = ph_d;
      S_RAISE: begin
        mup_d  = 1'b1;
        lamp_d = ph_d;
      end
      default: begin
        flt_d  = 1'b1;
        lamp_d = 1'b1;
        buzz_d = 1'b1;
      end
    endcase
  end

  // State, counters, input conditioning and registered outputs.
  always_ff @(posedge mClk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_WARN;
      g_q     <= 1'b0;
      u_s_q   <= 1'b0;
      u_q     <= 1'b0;
      d_s_q   <= 1'b0;
      d_q     <= 1'b0;
      pre_q   <= '0;
      tmr_q   <= '0;
      fl_q    <= '0;
      ph_q    <= 1'b1;
      mup_q   <= 1'b0;
      mdn_q   <= 1'b0;
      lamp_q  <= 1'b1;
      buzz_q  <= 1'b1;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= bus.gate_open;
      u_s_q   <= bus.lim_up;
      u_q     <= u_s_q;
      d_s_q   <= bus.lim_down;
      d_q     <= d_s_q;
      pre_q   <= pre_d;
      tmr_q   <= tmr_d;
      fl_q    <= fl_d;
      ph_q    <= ph_d;
      mup_q   <= mup_d;
      mdn_q   <= mdn_d;
      lamp_q  <= lamp_d;
      buzz_q  <= buzz_d;
      flt_q   <= flt_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.motor_up   = mup_q;
  assign bus.motor_down = mdn_q;
  assign bus.warn_lamp  = lamp_q;
  assign bus.buzzer     = buzz_q;
  assign bus.gate_fault = flt_q;

endmodule
